// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_pkg
//  Description : Shared UART definitions. Holds the byte width, the default
//                RX FIFO geometry and the baud/oversample constants used by
//                the UART receiver, the transmitter and the RX byte FIFO.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package uart_rx_fifo_pkg;

  localparam int UART_BYTE_W     = 8;
  localparam int RX_FIFO_DEPTH   = 16;
  localparam int RX_FIFO_ADDR_W  = 4;
  localparam int UART_BAUD_DIV   = 326;
  localparam int UART_OVERSAMPLE = 16;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage : uart_rx_fifo_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Byte stream bundle between the UART receiver, the RX FIFO
//                and the downstream consumer.
//  Signals     : in_data/in_valid     - write strobe from the receiver
//                out_data/out_valid/out_ready - FWFT read handshake
//                count/full/overflow/clr_overflow - status and control
//  Modports    : master - producer/consumer side (drives in_*, out_ready,
//                         clr_overflow)
//                slave  - FIFO side
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = RX_FIFO_ADDR_W
) ();

  uart_byte_t        in_data;
  logic              in_valid;
  uart_byte_t        out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic              clr_overflow;

  modport master (
    output in_data, in_valid, out_ready, clr_overflow,
    input  out_data, out_valid, count, full, overflow
  );

  modport slave (
    input  in_data, in_valid, out_ready, clr_overflow,
    output out_data, out_valid, count, full, overflow
  );

endinterface : uart_rx_fifo_if
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : First-word-fall-through byte FIFO behind the UART receiver.
//                Captures every in_valid strobe (the receiver cannot stall),
//                drops bytes when full and records that in a sticky
//                overflow flag.
//  Ports       : clk  - system clock
//                rst  - synchronous, active-high reset
//                bus  - uart_rx_fifo_if.slave (data, handshake, status)
//  Parameters  : DEPTH  - byte entries, power of two, >= 2
//                ADDR_W - log2(DEPTH)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int ADDR_W = RX_FIFO_ADDR_W
) (
  input  wire logic     clk,
  input  wire logic     rst,
  uart_rx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0]   C_FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   C_CNT_ONE    = (ADDR_W+1)'(1);

  uart_byte_t        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL_COUNT);
  assign w_pop   = !w_empty && bus.out_ready;
  // A push into a full FIFO still lands when the head is leaving the same
  // cycle: the freed slot is exactly the one wr_ptr points at.
  assign w_push  = bus.in_valid && (!w_full || w_pop);
  assign w_drop  = bus.in_valid && w_full && !w_pop;

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - C_CNT_ONE;
      end
      // A drop in the same cycle as a clear must remain visible.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_mem[r_rd_ptr];
  assign bus.out_valid = !w_empty;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;

endmodule : uart_rx_fifo
`default_nettype wire
